// File: rtl/counter_checker.sv
// counter_checker
//   Receive-side monitor for the mode-controlled up/down/load counter.
//   Snoops the counter's inputs, predicts its next Q/rco, and compares the
//   prediction against the counter's registered outputs one cycle later.
//   Every divergence is flagged and counted in registers.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   enb        in   counter enable, as driven to the counter
//   modo       in   counter mode (00 +1, 01 -1, 10 +3, 11 load)
//   D          in   counter load data
//   Q          in   counter output under check
//   rco        in   counter ripple-carry output under check
//   clr_err    in   synchronous clear of error flags and counters
//   sync       out  model aligned, checking active
//   err        out  one-cycle pulse on any mismatch
//   err_q      out  one-cycle pulse on a Q mismatch
//   err_rco    out  one-cycle pulse on an rco mismatch
//   err_sticky out  set on first error, held until clr_err/reset
//   err_count  out  saturating count of mismatching cycles
//   chk_count  out  saturating count of compared cycles
module counter_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int CHK_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  input  logic             clr_err,
  output logic             sync,
  output logic             err,
  output logic             err_q,
  output logic             err_rco,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CHK_W-1:0] chk_count
);

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] exp_q;
  logic             exp_rco;
  logic             pend;

  // Extended sums: the extra top bit is the wrap-out used as predicted rco.
  logic [WIDTH:0]   sum_up1;
  logic [WIDTH:0]   sum_up3;
  logic [WIDTH-1:0] pred_q;
  logic             pred_rco;

  logic             compare;
  logic             mis_q;
  logic             mis_rco;
  logic             mis_any;

  assign sum_up1 = {1'b0, Q} + (WIDTH+1)'(1);
  assign sum_up3 = {1'b0, Q} + (WIDTH+1)'(3);

  // Next prediction is built from the observed Q rather than the previous
  // prediction, so a single corrupted value produces exactly one error.
  always_comb begin
    pred_q   = Q;
    pred_rco = 1'b0;
    if (enb) begin
      case (modo)
        2'b00: begin
          pred_q   = sum_up1[WIDTH-1:0];
          pred_rco = sum_up1[WIDTH];
        end
        2'b01: begin
          pred_q   = Q - WIDTH'(1);
          pred_rco = (Q == '0);
        end
        2'b10: begin
          pred_q   = sum_up3[WIDTH-1:0];
          pred_rco = sum_up3[WIDTH];
        end
        default: begin
          pred_q   = D;
          pred_rco = 1'b0;
        end
      endcase
    end
  end

  assign compare = (state == SYNC) && pend;
  assign mis_q   = (Q != exp_q);
  assign mis_rco = (rco != exp_rco);
  assign mis_any = compare && (mis_q || mis_rco);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNSYNC;
      exp_q      <= '0;
      exp_rco    <= 1'b0;
      pend       <= 1'b0;
      sync       <= 1'b0;
      err        <= 1'b0;
      err_q      <= 1'b0;
      err_rco    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      chk_count  <= '0;
    end else begin
      case (state)
        UNSYNC: begin
          // No comparisons until a load tells us what Q must be.
          err     <= 1'b0;
          err_q   <= 1'b0;
          err_rco <= 1'b0;
          if (enb && modo == 2'b11) begin
            exp_q   <= D;
            exp_rco <= 1'b0;
            pend    <= 1'b1;
            sync    <= 1'b1;
            state   <= SYNC;
          end
        end
        SYNC: begin
          err     <= mis_any;
          err_q   <= compare && mis_q;
          err_rco <= compare && mis_rco;
          exp_q   <= pred_q;
          exp_rco <= pred_rco;
          pend    <= 1'b1;
        end
        default: state <= UNSYNC;
      endcase

      // A clear that coincides with a compare/mismatch keeps that event.
      if (clr_err) begin
        err_count  <= mis_any ? CNT_W'(1) : '0;
        chk_count  <= compare ? CHK_W'(1) : '0;
        err_sticky <= mis_any;
      end else begin
        if (compare && chk_count != '1)
          chk_count <= chk_count + CHK_W'(1);
        if (mis_any && err_count != '1)
          err_count <= err_count + CNT_W'(1);
        if (mis_any)
          err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Testbench for counter_checker (WIDTH=4). The bench plays the counter,
// optionally corrupting its outputs, and compares the checker's registers
// against an arithmetic reference model every cycle.
module tb_counter_checker;

  logic       clk;
  logic       reset;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] D;
  logic [3:0] Q;
  logic       rco;
  logic       clr_err;
  logic       sync;
  logic       err;
  logic       err_q;
  logic       err_rco;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [15:0] chk_count;

  counter_checker #(.WIDTH(4), .CNT_W(8), .CHK_W(16)) dut (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D), .Q(Q),
    .rco(rco), .clr_err(clr_err), .sync(sync), .err(err), .err_q(err_q),
    .err_rco(err_rco), .err_sticky(err_sticky), .err_count(err_count),
    .chk_count(chk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_sync, m_pred, m_prco, m_errq, m_errr, m_err, m_sticky, m_errc, m_chkc;
  // emulated counter's current output
  int cur_q;
  bit cur_rco;

  task automatic chk_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter contract in plain integer arithmetic.
  function automatic void golden(input int q, input bit e, input int m, input int d,
                                 output int nq, output bit nr);
    int s;
    if (!e) begin
      nq = q;
      nr = 1'b0;
      return;
    end
    case (m)
      0: s = q + 1;
      1: s = q - 1;
      2: s = q + 3;
      default: s = d;
    endcase
    nr = (m != 3) && (s > 15 || s < 0);
    nq = (s + 16) % 16;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_pred = 0; m_prco = 0; m_errq = 0; m_errr = 0; m_err = 0;
    m_sticky = 0; m_errc = 0; m_chkc = 0;
  endtask

  task automatic model_edge();
    int nq;
    bit nr;
    if (!m_sync) begin
      m_errq = 0; m_errr = 0; m_err = 0;
      if (clr_err) begin m_errc = 0; m_chkc = 0; m_sticky = 0; end
      if (enb && modo == 2'd3) begin
        m_sync = 1; m_pred = int'(D); m_prco = 0;
      end
    end else begin
      m_errq = (int'(Q) != m_pred);
      m_errr = (int'(rco) != m_prco);
      m_err  = m_errq | m_errr;
      if (clr_err) begin
        m_chkc = 1; m_errc = m_err; m_sticky = m_err;
      end else begin
        if (m_chkc < 65535) m_chkc++;
        if (m_err && m_errc < 255) m_errc++;
        if (m_err) m_sticky = 1;
      end
      golden(int'(Q), enb, int'(modo), int'(D), nq, nr);
      m_pred = nq;
      m_prco = nr;
    end
  endtask

  task automatic check_all();
    chk_eq("sync", sync, m_sync);
    chk_eq("err", err, m_err);
    chk_eq("err_q", err_q, m_errq);
    chk_eq("err_rco", err_rco, m_errr);
    chk_eq("err_sticky", err_sticky, m_sticky);
    chk_eq("err_count", err_count, m_errc);
    chk_eq("chk_count", chk_count, m_chkc);
  endtask

  // One cycle: present counter inputs and (possibly corrupted) outputs,
  // clock, update the model and the emulated counter, check at negedge.
  task automatic present(input bit e, input int m, input int d, input int q,
                         input bit r, input bit c);
    int nq;
    bit nr;
    enb = e; modo = 2'(m); D = 4'(d); Q = 4'(q); rco = r; clr_err = c;
    @(posedge clk);
    model_edge();
    golden(q, e, m, d, nq, nr);
    cur_q = nq;
    cur_rco = nr;
    @(negedge clk);
    check_all();
  endtask

  task automatic good(input bit e, input int m, input int d, input bit c);
    present(e, m, d, cur_q, cur_rco, c);
  endtask

  initial begin
    reset = 1'b1; enb = 0; modo = 0; D = 0; Q = 0; rco = 0; clr_err = 0;
    cur_q = 0; cur_rco = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Unloaded counter: no sync, no checks.
    for (int i = 0; i < 5; i++)
      present(1'b1, 0, 0, int'($urandom % 16), 1'($urandom % 2), 1'b0);
    chk_eq("unsync_sync", sync, 0);
    chk_eq("unsync_chk", chk_count, 0);

    // Load 1010 and count up through the wrap.
    good(1'b1, 3, 10, 1'b0);
    for (int i = 0; i < 7; i++) good(1'b1, 0, 0, 1'b0);
    chk_eq("up_sync", sync, 1);
    chk_eq("up_chk7", chk_count, 7);
    chk_eq("up_errc0", err_count, 0);

    // Single corruption: 0101 where 0100 expected, then self-heal.
    for (int i = 0; i < 3; i++) good(1'b1, 0, 0, 1'b0);
    present(1'b1, 0, 0, 5, 1'b0, 1'b0);
    chk_eq("inj_err", err, 1);
    chk_eq("inj_err_q", err_q, 1);
    for (int i = 0; i < 3; i++) good(1'b1, 0, 0, 1'b0);
    chk_eq("inj_err_after", err, 0);
    chk_eq("inj_errc1", err_count, 1);
    chk_eq("inj_sticky", err_sticky, 1);

    // Down wrap with missing rco.
    good(1'b1, 3, 0, 1'b0);
    good(1'b1, 1, 0, 1'b0);
    present(1'b1, 0, 0, 15, 1'b0, 1'b0);
    chk_eq("dn_err_rco", err_rco, 1);
    chk_eq("dn_err_q", err_q, 0);

    // +3 wrap from 1110 -> 0001 with rco.
    good(1'b1, 3, 14, 1'b0);
    good(1'b1, 2, 0, 1'b0);
    good(1'b1, 0, 0, 1'b0);
    chk_eq("up3_err", err, 0);

    // Disabled: hold is fine, spurious rco is not.
    good(1'b0, 0, 0, 1'b0);
    good(1'b0, 0, 0, 1'b0);
    chk_eq("hold_err", err, 0);
    present(1'b0, 0, 0, cur_q, 1'b1, 1'b0);
    chk_eq("hold_rco", err_rco, 1);

    // Saturation of err_count.
    good(1'b0, 0, 0, 1'b1);
    chk_eq("clr_errc", err_count, 0);
    for (int i = 0; i < 256; i++) present(1'b0, 0, 0, cur_q ^ 1, 1'b0, 1'b0);
    chk_eq("sat_errc", err_count, 255);
    present(1'b0, 0, 0, cur_q ^ 1, 1'b0, 1'b1);
    chk_eq("clrmis_errc", err_count, 1);
    chk_eq("clrmis_sticky", err_sticky, 1);
    chk_eq("clrmis_chk", chk_count, 1);

    // Async reset mid-SYNC with three errors recorded.
    good(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) present(1'b0, 0, 0, cur_q ^ 2, 1'b0, 1'b0);
    chk_eq("pre_rst_errc", err_count, 3);
    #2 reset = 1'b1;
    #1;
    chk_eq("arst_sync", sync, 0);
    chk_eq("arst_err", err, 0);
    chk_eq("arst_err_q", err_q, 0);
    chk_eq("arst_err_rco", err_rco, 0);
    chk_eq("arst_sticky", err_sticky, 0);
    chk_eq("arst_errc", err_count, 0);
    chk_eq("arst_chk", chk_count, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) good(1'b1, 0, 0, 1'b0);
    chk_eq("post_rst_sync", sync, 0);
    good(1'b1, 3, 5, 1'b0);
    chk_eq("reload_sync", sync, 1);

    // Randomized traffic with occasional corruption and clears.
    for (int i = 0; i < 300; i++) begin
      bit e, corrupt, c, r;
      int m, d, q;
      e = ($urandom % 4) != 0;
      m = int'($urandom % 4);
      d = int'($urandom % 16);
      c = ($urandom % 20) == 0;
      corrupt = ($urandom % 5) == 0;
      q = cur_q;
      r = cur_rco;
      if (corrupt) begin
        if ($urandom % 2) q = cur_q ^ int'($urandom_range(1, 15));
        else r = ~cur_rco;
      end
      present(e, m, d, q, r, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
